// File: rtl/fp_pkg.sv
// Shared types and constants for the FP add scheduler and related shared-resource blocks.
package fp_pkg;

  localparam int unsigned FP_WIDTH = 32;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Two passes replace a modulo index: [rr_ptr..NREQ-1] first, then [0..rr_ptr-1].
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any && req[k] && (k >= 32'(rr_ptr))) begin
        any             = 1'b1;
        grant_onehot[k] = 1'b1;
        grant_idx       = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any && req[k] && (k < 32'(rr_ptr))) begin
        any             = 1'b1;
        grant_onehot[k] = 1'b1;
        grant_idx       = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one start/done FP adder among NREQ requesters, round-robin, one op in flight,
// with a watchdog that answers a quiet NaN if the adder never completes.
module fp_add_scheduler
  import fp_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [FP_WIDTH*NREQ-1:0] req_a,
  input  logic [FP_WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic                     add_start,
  output logic [31:0]              add_a,
  output logic [31:0]              add_b,
  input  logic                     add_done,
  input  logic [31:0]              add_result,
  output logic                     busy,
  output logic [15:0]              op_count
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned TW    = $clog2(TIMEOUT);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, owner, grant_idx;
  logic [NREQ-1:0]   grant_onehot;
  logic              grant_any;
  logic [TW-1:0]     timer;
  logic [31:0]       sel_a, sel_b;
  logic              timeout_hit;
  logic              rsp_accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req          (req_valid),
    .rr_ptr       (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_onehot[i]) begin
        sel_a = req_a[i*FP_WIDTH +: FP_WIDTH];
        sel_b = req_b[i*FP_WIDTH +: FP_WIDTH];
      end
    end
  end

  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign rsp_accept  = (state == S_RESP) && rsp_ready[owner];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (add_done || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_accept) state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE) ? grant_onehot : '0;
    add_start = (state == S_ISSUE);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      owner     <= '0;
      timer     <= '0;
      op_count  <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_any) begin
            add_a <= sel_a;
            add_b <= sel_b;
            owner <= grant_idx;
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          // A done arriving on the last watchdog cycle still counts as a real result.
          if (add_done) begin
            rsp_data  <= add_result;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << owner;
          end else if (timeout_hit) begin
            rsp_data  <= FP_QNAN;
            rsp_err   <= 1'b1;
            rsp_valid <= NREQ'(1) << owner;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_accept) begin
            rsp_valid <= '0;
            op_count  <= op_count + 1'b1;
            rr_ptr    <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fp_add_scheduler.md
Name: fp_add_scheduler

Overview:
- Shares one non-pipelined floating-point add unit (start/done interface) between NREQ requesters.
- Round-robin arbitration, one operation in flight, per-requester valid/ready request and response handshakes.
- Watchdog timeout returns a quiet NaN if the adder never signals done.
- Sits between requesting datapath blocks and the single FP adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum WAIT cycles before abort (>=2).
- IDX_W, clog2(NREQ), localparam, requester index width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  32*NREQ  operand A, IEEE-754 single; slice i = bits [32i+31:32i]
- req_b  in  32*NREQ  operand B, same packing
- req_ready  out  NREQ  one-hot accept
- rsp_valid  out  NREQ  one-hot response valid
- rsp_data  out  32  result, shared by all requesters
- rsp_err  out  1  response is a timeout abort
- rsp_ready  in  NREQ  per-requester response accept
- add_start  out  1  one-cycle start pulse to adder
- add_a  out  32  adder operand A
- add_b  out  32  adder operand B
- add_done  in  1  adder result valid, one-cycle pulse
- add_result  in  32  adder sum
- busy  out  1  high when state != IDLE
- op_count  out  16  completed responses, wraps at 0xFFFF->0

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, timer=0, op_count=0.
  - All outputs 0: add_a, add_b, rsp_data, rsp_err, add_start, req_ready, rsp_valid, busy.
- Reset mid-operation aborts the transaction silently; no response is issued.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - grant = first asserted req_valid scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready = onehot(grant), combinational, only in IDLE. The handshake completes in that cycle.
  - Latch operands into add_a/add_b and grant into owner; go to ISSUE.
  - No req_valid: stay in IDLE.
  - Requesters must hold req_valid and operands stable until ready; dropping valid early is illegal.
- ISSUE:
  - add_start=1 for exactly this cycle; add_a/add_b are held stable through WAIT.
  - timer=0; go to WAIT.
- WAIT:
  - add_done=1: rsp_data<=add_result, rsp_err<=0, go to RESP.
  - Else, timer==TIMEOUT-1: rsp_data<=32'h7FC00000, rsp_err<=1, go to RESP.
  - Else timer++.
  - add_done and timeout in the same cycle: done wins, rsp_err=0.
- RESP:
  - rsp_valid[owner]=1, registered; rsp_data and rsp_err held stable.
  - On rsp_ready[owner]: rsp_valid cleared, op_count++, rr_ptr <= (owner+1) mod NREQ, go to IDLE.
  - rsp_ready of non-owners is ignored. No new grant while in RESP.
- add_done outside WAIT is ignored, including a late done after a timeout or reset.
- Latency with adder latency L (start to done) and immediate rsp_ready:
  - accept at cycle T, add_start at T+1, done at T+1+L, rsp_valid at T+2+L.
  - Earliest next accept: T+3+L.
- Fairness: a requester holding valid is granted within NREQ transactions.
- The block does no arithmetic on operands; the FP adder owns all sign, exponent and mantissa handling.

Decomposition:
- Package fp_pkg:
  - FP_QNAN = 32'h7FC00000.
  - FP_WIDTH = 32.
  - State encoding constants S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_RESP=3.
- Sub-module rr_arbiter (param NREQ):
  - Combinational: inputs req vector and rr_ptr; outputs grant_onehot, grant_idx, any.
  - Reused by later shared-resource schedulers.

Test Plan:
- Single request from requester 2, a=32'h42000000, b=32'hC1200000, adder model L=3 returns 32'h41B00000 -> req_ready=4'b0100 once; add_start one cycle later; rsp_valid=4'b0100 with rsp_data=32'h41B00000, rsp_err=0; op_count=1.
- All four req_valid held high continuously, rsp_ready tied high -> grant order 0,1,2,3,0; one add_start per transaction; busy drops to 0 only for one IDLE cycle between transactions.
- Adder model never asserts add_done, TIMEOUT=16 -> rsp_valid 16 cycles after WAIT entry with rsp_data=32'h7FC00000, rsp_err=1. A late add_done afterward is ignored: no second response, op_count +1 only.
- rsp_ready[owner] held low 5 cycles, other requesters valid -> rsp_valid/rsp_data stable; req_ready stays 0; no add_start until the response is accepted.
- reset asserted during WAIT -> all outputs 0 immediately (async); a late add_done after release is ignored; next request is granted starting from requester 0.
- add_done on the same cycle timer reaches TIMEOUT-1 -> rsp_err=0, rsp_data=add_result.
